determinant_calculator2_2_controller: RTL

DETERMINANT_CALCULATOR2_2_CONTROLLER -- requirements
Module: determinant_calculator2_2_controller

---
 rtl/det2x2_pkg.sv | 28 ++
 rtl/determinant_calculator2_2_controller.sv | 111 +++++++++++
 2 files changed

// File: rtl/det2x2_pkg.sv
// Shared types and constants for the 2x2 determinant controller and its datapath.
package det2x2_pkg;

    localparam int unsigned Z_W    = 3;
    localparam int unsigned N_ELEM = 4;
    localparam int unsigned N_CMP  = 3;
    localparam int unsigned EN_W   = N_ELEM + N_CMP;

    localparam logic [Z_W-1:0] LAST_ELEM = 3'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        MUL_AD = 3'd2,
        MUL_BC = 3'd3,
        SUB    = 3'd4,
        DONE   = 3'd5
    } state_t;

    // Element-register enable for counter value z; values past the last element pin to it.
    function automatic logic [N_ELEM-1:0] load_onehot(input logic [Z_W-1:0] z,
                                                      input logic [Z_W-1:0] last);
        logic [Z_W-1:0] idx;
        idx = (z > last) ? last : z;
        load_onehot = {1'b1, {(N_ELEM-1){1'b0}}} >> idx;
    endfunction

endpackage

// File: rtl/determinant_calculator2_2_controller.sv
// Sequencing FSM for the 2x2 determinant datapath: loads a..d, forms a*d and b*c,
// subtracts, then holds the result until the consumer acknowledges.
module determinant_calculator2_2_controller
    import det2x2_pkg::*;
#(
    parameter logic [Z_W-1:0] LAST_ELEM = det2x2_pkg::LAST_ELEM
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             ack,
    input  logic [Z_W-1:0]   z,
    output logic [1:EN_W]    en,
    output logic             s1,
    output logic             cload,
    output logic             cen,
    output logic             busy,
    output logic             done
);

    state_t              r_state;
    state_t              w_state_nxt;

    logic [N_CMP-1:0]    r_en_cmp;
    logic                r_s1;
    logic                r_busy;
    logic                r_done;

    logic [N_ELEM-1:0]   w_en_load;
    logic                w_cload;
    logic                w_cen;
    logic [N_CMP-1:0]    w_en_cmp_nxt;
    logic                w_s1_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;

    // State and Moore-output registers; Moore outputs are precomputed from the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_en_cmp <= '0;
            r_s1     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_en_cmp <= w_en_cmp_nxt;
            r_s1     <= w_s1_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_en_load    = '0;
        w_cload      = 1'b0;
        w_cen        = 1'b0;
        w_en_cmp_nxt = '0;
        w_s1_nxt     = 1'b0;
        w_busy_nxt   = 1'b1;
        w_done_nxt   = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_cload     = 1'b1;
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                w_cen     = 1'b1;
                w_en_load = load_onehot(z, LAST_ELEM);
                if (z >= LAST_ELEM) begin
                    w_state_nxt = MUL_AD;
                end
            end
            MUL_AD: w_state_nxt = MUL_BC;
            MUL_BC: w_state_nxt = SUB;
            SUB:    w_state_nxt = DONE;
            DONE: begin
                if (ack) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Moore outputs of the state about to be entered
        unique case (w_state_nxt)
            IDLE:   w_busy_nxt = 1'b0;
            MUL_AD: w_en_cmp_nxt = 3'b100;
            MUL_BC: begin
                w_en_cmp_nxt = 3'b010;
                w_s1_nxt     = 1'b1;
            end
            SUB:    w_en_cmp_nxt = 3'b001;
            DONE:   w_done_nxt = 1'b1;
            default: w_busy_nxt = 1'b1;
        endcase
    end

    // Mealy outputs are masked by reset so a start held during reset cannot leak through.
    assign cload = reset & w_cload;
    assign cen   = reset & w_cen;
    assign en    = {w_en_load & {N_ELEM{reset}}, r_en_cmp};
    assign s1    = r_s1;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
